bcd_ssd_scan: RTL and testbench
===============================

BCD_SSD_SCAN -- requirements
Module: bcd_ssd_scan

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, Clk cycles per displayed digit (1 kHz digit rate at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have port Clk  input  1  system clock; all state is on its rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Clk_Div  input  1  slow divided clock from the clock divider, treated as asynchronous data and never used as a clock.
REQ-005 SHALL have port En  input  1  count enable.
REQ-006 SHALL have port Up  input  1  direction: 1 counts up, 0 counts down.
REQ-007 SHALL have port Clr  input  1  synchronous clear of the count.
REQ-008 SHALL have port Count  output  16  4-digit packed BCD value; [3:0] is the least significant digit.
REQ-009 SHALL have port Seg  output  7  active-low segments, Seg[6]=a through Seg[0]=g, registered.
REQ-010 SHALL have port An  output  4  active-low digit anodes, one-hot low, An[0]=least significant digit, registered.
REQ-011 SHALL have port Dp  output  1  active-low decimal point, registered.

Function
REQ-012 SHALL pass Clk_Div through synchroniser flops s1 and s2, then through edge flop s3; tick = s2 & ~s3, high for exactly one Clk cycle per Clk_Div rising edge.
REQ-013 SHALL update Count on the Clk edge where tick is high, i.e. on the 3rd Clk edge after the first edge that samples Clk_Div high.
REQ-014 SHALL apply priority Clr > (tick & En) > hold; Clr clears Count to 16'h0000 on the next edge regardless of tick.
REQ-015 SHALL, on (tick & En & Up), increment Count with per-digit BCD carry: 0009->0010, 0099->0100, 9999->0000 (wrap).
REQ-016 SHALL, on (tick & En & ~Up), decrement Count with per-digit BCD borrow: 0010->0009, 1000->0999, 0000->9999 (wrap).
REQ-017 SHALL hold Count when En is low; ticks that occur while En is low are dropped, not queued.
REQ-018 SHALL run scan counter 0..SCAN_DIV-1; on the edge where it is at SCAN_DIV-1 it SHALL wrap to 0 and advance digit index 0->1->2->3->0.
REQ-019 SHALL register An = ~(4'b0001 << index) and Seg = decode(Count digit[index]) one cycle after the index/Count change.
REQ-020 SHALL decode digits 0-9 to standard patterns (0=7'b0000001, 1=7'b1001111, 8=7'b0000000); codes A-F SHALL decode to 7'b1111111 (blank).
REQ-021 SHALL drive Dp low only when index==0 and s2==1 (seconds heartbeat on the rightmost digit), else high.
REQ-022 SHALL keep Count stepping and digit scanning independent; a tick during a digit switch affects only the value displayed.

Reset
REQ-023 SHALL, while Rst_n is low, asynchronously force Count=16'h0000, scan counter=0, index=0, Seg=7'b1111111, An=4'b1111, Dp=1.
REQ-024 SHALL reset s1, s2 and s3 to 1, so that a Clk_Div that is high at reset release produces no tick; the first tick requires a low-then-high transition.
REQ-025 SHALL, when reset is asserted mid-count or mid-scan, discard all state, with no pending tick surviving reset.

Configuration
REQ-026 SHALL, with macro BCD_SSD_LZ_BLANK_EN defined, blank leading zero digits (Seg=7'b1111111 for each digit above the most significant non-zero digit); digit 0 SHALL always be shown, and An scanning is unchanged.
REQ-027 SHALL, without BCD_SSD_LZ_BLANK_EN, display all four digits including leading zeros.

Verification
REQ-028 SHALL cover reset: Rst_n low with Clk_Div high, then release -> Count=0000, An=1111, Seg=1111111, no tick until Clk_Div goes low then high.
REQ-029 SHALL cover up wrap: preload by ticking to 9999 with En=1, Up=1, then one Clk_Div pulse -> Count=0000 exactly 3 Clk edges after the rising sample.
REQ-030 SHALL cover down wrap: Count=0000, Up=0, one pulse -> 9999; next pulse -> 9998.
REQ-031 SHALL cover simultaneous events: Clr=1 on the tick cycle with Count=0042 -> 0000; with En=0, 5 pulses -> Count unchanged.
REQ-032 SHALL cover scanning: SCAN_DIV=4, Count=1234 -> An sequence 1110,1101,1011,0111 every 4 cycles with Seg showing 4,3,2,1 respectively.
REQ-033 SHALL cover blanking: Count=0007 with BCD_SSD_LZ_BLANK_EN -> digits 3..1 show 1111111 and digit 0 shows 7; without the macro -> 0,0,0,7.

Source files
------------

// File: rtl/bcd_ssd_scan.sv
// -----------------------------------------------------------------------------
// bcd_ssd_scan
//
// Four-digit BCD up/down counter driving a multiplexed, common-anode
// seven-segment display.
//
// The counter advances once per rising edge of Clk_Div. Clk_Div is a slow,
// divided clock that is only ever treated as asynchronous data, never as a
// clock. The display is refreshed by scanning one digit at a time. Each digit
// is shown for SCAN_DIV cycles of Clk.
//
// Optional build macro:
//   BCD_SSD_LZ_BLANK_EN
//     When defined, leading zero digits are blanked. Digit 0 is always
//     shown, and the anode scan pattern is not affected.
//     When undefined, all four digits are shown, including leading zeros.
//
// Parameters:
//   SCAN_DIV  Clk cycles per displayed digit. Legal range is 2 .. 2^20.
//
// Ports:
//   Clk      in   system clock; all state changes on its rising edge
//   Rst_n    in   asynchronous active-low reset
//   Clk_Div  in   slow divided clock, synchronised here as data
//   En       in   count enable
//   Up       in   count direction (1 = up, 0 = down)
//   Clr      in   synchronous clear of the count; has priority over counting
//   Count    out  [15:0] packed BCD count; [3:0] is the least significant digit
//   Seg      out  [6:0] active-low segments; Seg[6] = a ... Seg[0] = g
//   An       out  [3:0] active-low one-hot digit anodes; An[0] = rightmost digit
//   Dp       out  active-low decimal point (heartbeat shown on digit 0)
// -----------------------------------------------------------------------------
module bcd_ssd_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Clk_Div,
    input  logic        En,
    input  logic        Up,
    input  logic        Clr,
    output logic [15:0] Count,
    output logic [6:0]  Seg,
    output logic [3:0]  An,
    output logic        Dp
);

    localparam int              SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Synchroniser stages (s1, s2) followed by an edge-detect stage (s3).
    logic s1;
    logic s2;
    logic s3;
    logic tick;

    // Scan state: dwell counter and index of the digit currently displayed.
    logic [SCAN_W-1:0] scan_cnt;
    logic [1:0]        digit_idx;

    // Combinational next values for the registered display outputs.
    logic [3:0] cur_digit;
    logic       lead_blank;
    logic [6:0] seg_next;
    logic [3:0] an_next;
    logic       dp_next;

    // -------------------------------------------------------------------------
    // BCD helpers
    // -------------------------------------------------------------------------

    // Adds one with a ripple carry between decimal digits. A digit at 9 rolls
    // to 0 and passes the carry up. 9999 therefore wraps to 0000.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] >= 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Subtracts one with a ripple borrow between decimal digits. A digit at 0
    // rolls to 9 and passes the borrow up. 0000 therefore wraps to 9999.
    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (v[i*4 +: 4] == 4'd0) begin
                    r[i*4 +: 4] = 4'd9;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Active-low segment patterns in the order a..g, with a in the MSB.
    // Non-decimal codes are shown as a blank digit rather than as hex glyphs.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // -------------------------------------------------------------------------
    // Clk_Div synchroniser and rising-edge detector.
    //
    // All three stages reset high. If Clk_Div is already high when reset is
    // released, this looks like a level rather than an edge, so no tick is
    // produced. A tick needs a genuine low-to-high transition after reset.
    // Because the stages are reset, any edge still in the pipe when reset
    // arrives is discarded.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= Clk_Div;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick = s2 & ~s3;

    // -------------------------------------------------------------------------
    // BCD count register.
    //
    // Clear always wins. After that, an enabled tick steps the count in the
    // selected direction. A tick that arrives while En is low is dropped; it
    // is not held over for later.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Count <= 16'h0000;
        end else if (Clr) begin
            Count <= 16'h0000;
        end else if (tick && En) begin
            Count <= Up ? bcd_inc(Count) : bcd_dec(Count);
        end
    end

    // -------------------------------------------------------------------------
    // Digit scan timing.
    //
    // The dwell counter runs from 0 to SCAN_DIV-1. On the cycle it wraps, the
    // digit index advances. The 2-bit index wraps naturally from 3 back to 0.
    // This block is deliberately independent of the count logic.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt  <= scan_cnt + SCAN_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Select the BCD digit that belongs to the current scan position.
    // -------------------------------------------------------------------------
    always_comb begin
        cur_digit = Count[3:0];
        case (digit_idx)
            2'd0:    cur_digit = Count[3:0];
            2'd1:    cur_digit = Count[7:4];
            2'd2:    cur_digit = Count[11:8];
            2'd3:    cur_digit = Count[15:12];
            default: cur_digit = Count[3:0];
        endcase
    end

`ifdef BCD_SSD_LZ_BLANK_EN
    // -------------------------------------------------------------------------
    // Leading-zero blanking.
    //
    // A digit is blanked when it, and every digit above it, is zero. Digit 0
    // is never blanked, so a count of zero still shows a single "0".
    // -------------------------------------------------------------------------
    always_comb begin
        lead_blank = 1'b0;
        case (digit_idx)
            2'd1:    lead_blank = (Count[15:4]  == 12'h000);
            2'd2:    lead_blank = (Count[15:8]  == 8'h00);
            2'd3:    lead_blank = (Count[15:12] == 4'h0);
            default: lead_blank = 1'b0;
        endcase
    end
`else
    // Every digit is shown, including leading zeros.
    assign lead_blank = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Next values for the display outputs.
    //
    // The decimal point is a heartbeat: it is lit on the rightmost digit
    // whenever the synchronised Clk_Div level is high.
    // -------------------------------------------------------------------------
    always_comb begin
        seg_next = lead_blank ? SEG_BLANK : seg_decode(cur_digit);
        an_next  = ~(4'b0001 << digit_idx);
        dp_next  = ~((digit_idx == 2'd0) & s2);
    end

    // -------------------------------------------------------------------------
    // Registered display outputs.
    //
    // Registering these keeps the pins glitch-free. It also means the outputs
    // trail the index and count by one cycle. During reset the display is
    // fully dark.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Seg <= SEG_BLANK;
            An  <= 4'b1111;
            Dp  <= 1'b1;
        end else begin
            Seg <= seg_next;
            An  <= an_next;
            Dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_bcd_ssd_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_ssd_scan
//
// Directed, self-checking bench for bcd_ssd_scan, built with SCAN_DIV = 4.
//
// The expected count is kept as a plain decimal integer and converted to
// packed BCD only when it is compared. Expected segment patterns are written
// out by hand. Set BCD_SSD_LZ_BLANK_EN to the same value used for the RTL.
// -----------------------------------------------------------------------------
module tb_bcd_ssd_scan;

    localparam int SCAN_DIV = 4;

    logic        Clk;
    logic        Rst_n;
    logic        Clk_Div;
    logic        En;
    logic        Up;
    logic        Clr;
    logic [15:0] Count;
    logic [6:0]  Seg;
    logic [3:0]  An;
    logic        Dp;

    int checks;
    int errors;
    int exp_val;

    bcd_ssd_scan #(.SCAN_DIV(SCAN_DIV)) dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .Clk_Div (Clk_Div),
        .En      (En),
        .Up      (Up),
        .Clr     (Clr),
        .Count   (Count),
        .Seg     (Seg),
        .An      (An),
        .Dp      (Dp)
    );

    // 100 MHz system clock.
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Safety net in case some wait never completes.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Converts a decimal value in the range 0..9999 to packed BCD.
    function automatic logic [15:0] toBcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'(v / 1000);
        return r;
    endfunction

    // Hand-written active-low segment patterns (a..g, a in the MSB).
    function automatic logic [6:0] segOf(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            7:       return 7'b0001111;
            default: return 7'b1111111;
        endcase
    endfunction

    // Compares one observed value against its expected value and tallies
    // the result.
    task automatic checkOutput(input string tag, input logic [15:0] actual,
                               input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Applies the control inputs just after a falling edge of Clk.
    task automatic applyStimulus(input logic en, input logic up, input logic clr);
        @(negedge Clk);
        En  = en;
        Up  = up;
        Clr = clr;
    endtask

    // Updates the reference count for one accepted tick.
    task automatic stepModel();
        if (En) exp_val = Up ? (exp_val + 1) % 10000 : (exp_val + 9999) % 10000;
    endtask

    // One full Clk_Div period: high for 3 Clk cycles, then low for 3.
    task automatic pulseClkDiv(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge Clk);
            Clk_Div = 1'b1;
            repeat (3) @(negedge Clk);
            Clk_Div = 1'b0;
            repeat (3) @(negedge Clk);
            stepModel();
        end
    endtask

    // A Clk_Div pulse that also checks when the count changes. The count
    // must still be unchanged after the 2nd edge that follows the rising
    // input, and must be updated after the 3rd.
    task automatic pulseTimed(input string tag);
        int old_val;
        old_val = exp_val;
        @(negedge Clk);
        Clk_Div = 1'b1;
        repeat (2) @(negedge Clk);
        checkOutput({tag, "_hold"}, Count, toBcd(old_val));
        @(negedge Clk);
        stepModel();
        checkOutput({tag, "_step"}, Count, toBcd(exp_val));
        Clk_Div = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    // Waits, for a bounded number of cycles, until An equals the given value.
    task automatic waitAn(input string tag, input logic [3:0] target);
        int n;
        n = 0;
        while (An !== target && n < 50) begin
            @(negedge Clk);
            n++;
        end
        checkOutput(tag, {12'h0, An}, {12'h0, target});
    endtask

    // Walks one full scan, starting at the first cycle of digit 0. For each
    // digit it checks An, Seg and Dp, and confirms the digit dwells for
    // exactly SCAN_DIV cycles.
    task automatic checkScan(input string tag, input logic [6:0] s0,
                             input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3);
        logic [6:0] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg[0] = s0;
        exp_seg[1] = s1;
        exp_seg[2] = s2;
        exp_seg[3] = s3;
        waitAn({tag, "_sync3"}, 4'b0111);
        waitAn({tag, "_sync0"}, 4'b1110);
        for (int k = 0; k < 4; k++) begin
            exp_an = ~(4'b0001 << k);
            checkOutput({tag, "_an"},  {12'h0, An},  {12'h0, exp_an});
            checkOutput({tag, "_seg"}, {9'h0, Seg},  {9'h0, exp_seg[k]});
            checkOutput({tag, "_dp"},  {15'h0, Dp},  16'h0001);
            repeat (SCAN_DIV - 1) @(negedge Clk);
            checkOutput({tag, "_dwell"}, {12'h0, An}, {12'h0, exp_an});
            @(negedge Clk);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_val = 0;
        Rst_n   = 1'b0;
        Clk_Div = 1'b1;
        En      = 1'b1;
        Up      = 1'b1;
        Clr     = 1'b0;

        // Reset held with Clk_Div high. Release it and confirm no tick occurs.
        repeat (3) @(negedge Clk);
        checkOutput("rst_count", Count, 16'h0000);
        checkOutput("rst_an",    {12'h0, An},  16'h000f);
        checkOutput("rst_seg",   {9'h0, Seg},  16'h007f);
        checkOutput("rst_dp",    {15'h0, Dp},  16'h0001);
        Rst_n = 1'b1;
        repeat (10) @(negedge Clk);
        checkOutput("rst_no_tick", Count, 16'h0000);
        Clk_Div = 1'b0;
        repeat (3) @(negedge Clk);
        pulseClkDiv(1);
        checkOutput("first_tick", Count, toBcd(exp_val));

        // Down wrap 0000 -> 9999 -> 9998, then up wrap 9999 -> 0000.
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulseClkDiv(1);
        checkOutput("down_to0", Count, 16'h0000);
        pulseTimed("down_wrap");
        checkOutput("down_9999", Count, 16'h9999);
        pulseClkDiv(1);
        checkOutput("down_9998", Count, 16'h9998);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pulseClkDiv(1);
        checkOutput("up_9999", Count, 16'h9999);
        pulseTimed("up_wrap");
        checkOutput("up_0000", Count, 16'h0000);

        // Carries and borrows across decimal digit boundaries.
        pulseClkDiv(9);
        checkOutput("up_0009", Count, 16'h0009);
        pulseClkDiv(1);
        checkOutput("up_0010", Count, 16'h0010);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulseClkDiv(1);
        checkOutput("down_0009", Count, 16'h0009);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pulseClkDiv(90);
        checkOutput("up_0099", Count, 16'h0099);
        pulseClkDiv(1);
        checkOutput("up_0100", Count, 16'h0100);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulseClkDiv(1);
        checkOutput("down_0099", Count, 16'h0099);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pulseClkDiv(901);
        checkOutput("up_1000", Count, 16'h1000);
        applyStimulus(1'b1, 1'b0, 1'b0);
        pulseClkDiv(1);
        checkOutput("down_0999", Count, 16'h0999);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pulseClkDiv(235);
        checkOutput("up_1234", Count, toBcd(1234));

        // Scan the value 1234 while Clk_Div stays low.
        checkScan("scan1234", segOf(4), segOf(3), segOf(2), segOf(1));

        // Heartbeat: with Clk_Div held high and counting disabled, the
        // decimal point is lit only on digit 0.
        applyStimulus(1'b0, 1'b1, 1'b0);
        Clk_Div = 1'b1;
        repeat (4) @(negedge Clk);
        waitAn("dp_sync3", 4'b0111);
        waitAn("dp_sync0", 4'b1110);
        checkOutput("dp_digit0", {15'h0, Dp}, 16'h0000);
        repeat (SCAN_DIV) @(negedge Clk);
        checkOutput("dp_digit1", {15'h0, Dp}, 16'h0001);
        Clk_Div = 1'b0;
        repeat (3) @(negedge Clk);
        checkOutput("dp_tick_dropped", Count, toBcd(1234));

        // Clear with no tick, then clear on the same cycle as a tick.
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0);
        exp_val = 0;
        checkOutput("clr_plain", Count, 16'h0000);
        pulseClkDiv(42);
        checkOutput("up_0042", Count, 16'h0042);
        @(negedge Clk);
        Clk_Div = 1'b1;
        repeat (2) @(negedge Clk);
        Clr = 1'b1;
        @(negedge Clk);
        Clr = 1'b0;
        Clk_Div = 1'b0;
        exp_val = 0;
        checkOutput("clr_on_tick", Count, 16'h0000);
        repeat (3) @(negedge Clk);
        checkOutput("clr_after", Count, 16'h0000);

        // Ticks that arrive while En is low are dropped, not queued.
        pulseClkDiv(3);
        checkOutput("up_0003", Count, 16'h0003);
        applyStimulus(1'b0, 1'b1, 1'b0);
        pulseClkDiv(5);
        checkOutput("en_low_hold", Count, 16'h0003);
        applyStimulus(1'b1, 1'b1, 1'b0);
        pulseClkDiv(1);
        checkOutput("en_no_queue", Count, 16'h0004);

        // Leading-zero behaviour with the value 0007.
        pulseClkDiv(3);
        checkOutput("up_0007", Count, 16'h0007);
`ifdef BCD_SSD_LZ_BLANK_EN
        checkScan("scan0007", segOf(7), 7'b1111111, 7'b1111111, 7'b1111111);
`else
        checkScan("scan0007", segOf(7), segOf(0), segOf(0), segOf(0));
`endif

        // Reset arriving while a tick is still in the synchroniser.
        @(negedge Clk);
        Clk_Div = 1'b1;
        @(negedge Clk);
        Rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_count", Count, 16'h0000);
        checkOutput("mid_rst_an", {12'h0, An}, 16'h000f);
        @(negedge Clk);
        Rst_n = 1'b1;
        exp_val = 0;
        repeat (6) @(negedge Clk);
        checkOutput("mid_rst_no_tick", Count, 16'h0000);
        Clk_Div = 1'b0;
        repeat (3) @(negedge Clk);
        pulseClkDiv(1);
        checkOutput("mid_rst_recover", Count, 16'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
